// File: rtl/m_seq_checker_if.sv
// m_seq_checker_if: bit-stream inputs and sync/error status outputs of the m-sequence checker.
interface m_seq_checker_if;
    logic        bit_clk_in;
    logic        m_seq_in;
    logic        in_sync;
    logic        bit_valid;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [15:0] period_cnt;
    modport master (output bit_clk_in, m_seq_in, input in_sync, bit_valid, err_pulse, err_cnt, period_cnt);
    modport slave  (input bit_clk_in, m_seq_in, output in_sync, bit_valid, err_pulse, err_cnt, period_cnt);
endinterface

// File: rtl/m_seq_checker.sv
// m_seq_checker: sync/error checker for the x^7+x^6+1 m-sequence (period 127).
// Define CHK_PERIOD_CNT_EN to build the completed-period counter; otherwise period_cnt is 0.
module m_seq_checker #(
    parameter int SYNC_BITS = 16,
    parameter int LOSS_ERRS = 8
) (
    input logic            clk_2m,
    input logic            rst,
    m_seq_checker_if.slave bus
);
    localparam int VW = $clog2(SYNC_BITS + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);
    typedef enum logic [1:0] {HUNT, LOAD, VERIFY, SYNC} state_t;
    state_t        state_q;
    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          stb_q, bit_q;
    logic [6:0]    r_q, r_free;
    logic [2:0]    load_q;
    logic [VW-1:0] ver_q;
    logic [6:0]    win_q;
    logic [EW-1:0] werr_q, werr_d;
    logic [15:0]   err_cnt_q;
    logic          in_sync_q, bit_valid_q, err_pulse_q;
    logic          pred, mis;
    always_comb begin
        pred   = r_q[6] ^ r_q[5];
        mis    = bit_q ^ pred;
        r_free = {r_q[5:0], pred};
        // A wrap and an error on the same bit land the error in the fresh window.
        werr_d = (win_q == 7'd126 ? '0 : werr_q) + EW'(mis);
    end
    always_ff @(posedge clk_2m) begin
        if (rst) begin
            state_q     <= HUNT;
            clk_sync_q  <= '0;
            dat_sync_q  <= '0;
            stb_q       <= 1'b0;
            bit_q       <= 1'b0;
            r_q         <= '0;
            load_q      <= '0;
            ver_q       <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_cnt_q   <= '0;
            in_sync_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], bus.bit_clk_in};
            dat_sync_q  <= {dat_sync_q[0], bus.m_seq_in};
            stb_q       <= clk_sync_q[1] & ~clk_sync_q[2];
            bit_q       <= dat_sync_q[1];
            bit_valid_q <= stb_q;
            err_pulse_q <= stb_q && state_q == SYNC && mis;
            if (stb_q) begin
                case (state_q)
                    // The bit that wakes HUNT is kept as the first loaded bit.
                    HUNT: begin
                        r_q     <= {r_q[5:0], bit_q};
                        load_q  <= 3'd1;
                        state_q <= LOAD;
                    end
                    LOAD: begin
                        r_q <= {r_q[5:0], bit_q};
                        if (load_q == 3'd6) begin
                            load_q <= '0;
                            if ({r_q[5:0], bit_q} != 7'd0) begin
                                state_q <= VERIFY;
                                ver_q   <= '0;
                            end
                        end else begin
                            load_q <= load_q + 3'd1;
                        end
                    end
                    VERIFY: begin
                        r_q <= {r_q[5:0], bit_q};
                        if (mis) begin
                            state_q <= HUNT;
                        end else if (ver_q == VW'(SYNC_BITS - 1)) begin
                            state_q   <= SYNC;
                            in_sync_q <= 1'b1;
                            err_cnt_q <= '0;
                            win_q     <= '0;
                            werr_q    <= '0;
                        end else begin
                            ver_q <= ver_q + VW'(1);
                        end
                    end
                    SYNC: begin
                        r_q    <= r_free;
                        win_q  <= win_q == 7'd126 ? '0 : win_q + 7'd1;
                        werr_q <= werr_d;
                        if (mis) begin
                            err_cnt_q <= &err_cnt_q ? err_cnt_q : err_cnt_q + 16'd1;
                            if (werr_d == EW'(LOSS_ERRS)) begin
                                state_q   <= HUNT;
                                in_sync_q <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end
`ifdef CHK_PERIOD_CNT_EN
    logic [15:0] period_q;
    always_ff @(posedge clk_2m) begin
        if (rst)
            period_q <= '0;
        else if (stb_q && state_q == SYNC && r_free == 7'h7F)
            period_q <= period_q + 16'd1;
    end
    assign bus.period_cnt = period_q;
`else
    assign bus.period_cnt = '0;
`endif
    assign bus.in_sync   = in_sync_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_m_seq_checker.sv
// tb_m_seq_checker: directed bit streams with per-bit expectations queued and checked on bit_valid.
module tb_m_seq_checker;
    logic clk_2m = 1'b0;
    logic rst    = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   bit_idx = 0;
    logic [17:0] exp_q[$];
    logic [6:0]  g = 7'h5A;
    m_seq_checker_if bus();
    m_seq_checker dut (.clk_2m(clk_2m), .rst(rst), .bus(bus));
    always #5 clk_2m = ~clk_2m;
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction
    function automatic logic nxt();
        logic b;
        b = g[6] ^ g[5];
        g = {g[5:0], b};
        return b;
    endfunction
    // Expected word per bit: {in_sync, err_pulse, err_cnt}.
    task automatic send(input logic b, input logic s, input logic e, input logic [15:0] c);
        exp_q.push_back({s, e, c});
        bus.m_seq_in = b;
        #37 bus.bit_clk_in = 1'b1;
        #80 bus.bit_clk_in = 1'b0;
        #43;
    endtask
    task automatic clean(input int n, input logic s, input logic [15:0] c);
        for (int i = 0; i < n; i++) send(nxt(), s, 1'b0, c);
    endtask
    task automatic flip(input logic s, input logic [15:0] c);
        send(~nxt(), s, 1'b1, c);
    endtask
    task automatic acquire(input logic [15:0] held);
        for (int j = 1; j <= 23; j++) send(nxt(), j == 23, 1'b0, j == 23 ? 16'd0 : held);
    endtask
    task automatic reset_check(input string tag);
        @(negedge clk_2m) rst = 1'b1;
        @(negedge clk_2m);
        check({tag, "_in_sync"}, 32'(bus.in_sync), 0);
        check({tag, "_bit_valid"}, 32'(bus.bit_valid), 0);
        check({tag, "_err_pulse"}, 32'(bus.err_pulse), 0);
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
        check({tag, "_period_cnt"}, 32'(bus.period_cnt), 0);
        rst = 1'b0;
    endtask
    always @(negedge clk_2m) begin
        if (bus.bit_valid) begin
            bit_idx++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL bit%0d: bit_valid with no expected entry", bit_idx);
            end else begin
                check($sformatf("bit%0d", bit_idx), 32'({bus.in_sync, bus.err_pulse, bus.err_cnt}), 32'(exp_q.pop_front()));
            end
        end
    end
    initial begin
        bus.bit_clk_in = 1'b0;
        bus.m_seq_in   = 1'b0;
        repeat (3) @(posedge clk_2m);
        reset_check("rst0");
        acquire(16'd0);
        clean(300, 1'b1, 16'd0);
        flip(1'b1, 16'd1);
        clean(89, 1'b1, 16'd1);
        for (int i = 0; i < 8; i++) begin
            flip(i < 7, 16'(2 + i));
            if (i < 7) clean(1, 1'b1, 16'(2 + i));
        end
        acquire(16'd9);
        for (int i = 0; i < 5; i++) begin
            flip(1'b1, 16'(i + 1));
            clean(1, 1'b1, 16'(i + 1));
        end
        reset_check("rst_sync");
        for (int i = 0; i < 60; i++) send(1'b0, 1'b0, 1'b0, 16'd0);
        reset_check("rst_zero");
        acquire(16'd0);
        clean(381, 1'b1, 16'd0);
        repeat (10) @(negedge clk_2m);
`ifdef CHK_PERIOD_CNT_EN
        check("period_cnt", 32'(bus.period_cnt), 3);
`else
        check("period_cnt", 32'(bus.period_cnt), 0);
`endif
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/m_seq_checker.md
M_SEQ_CHECKER -- requirements
Module: m_seq_checker

Interface
REQ-001 Parameter SYNC_BITS, default 16: consecutive correct predictions required to declare sync.
REQ-002 Parameter LOSS_ERRS, default 8: errors within one 127-bit window that force loss of sync.
REQ-003 Port clk_2m, input, 1: 2 MHz system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port bit_clk_in, input, 1: recovered 10 kHz bit clock from the DPLL, asynchronous to clk_2m.
REQ-006 Port m_seq_in, input, 1: received m-sequence, polynomial x^7+x^6+1, period 127.
REQ-007 Port in_sync, output, 1: checker is in state SYNC.
REQ-008 Port bit_valid, output, 1: one-cycle strobe per sampled bit.
REQ-009 Port err_pulse, output, 1: one-cycle strobe, coincident with bit_valid, on a mismatch while in SYNC.
REQ-010 Port err_cnt, output, 16: saturating total error count while in SYNC.
REQ-011 Port period_cnt, output, 16: count of completed sequence periods (see Configuration).

Function
REQ-012 Synchronisation: bit_clk_in and m_seq_in each pass a 2-flop synchroniser.
REQ-013 Sampling: the synchronised data bit is sampled on each synchronised bit_clk_in rising edge.
REQ-014 Latency: bit_valid asserts exactly 3 clk_2m cycles after the first clk_2m edge that samples bit_clk_in high.
REQ-015 Shift register r[6:0]: each sampled bit enters r[0]; r[6] is the oldest bit.
REQ-016 Prediction: predicted bit = r[6] XOR r[5].
REQ-017 States: HUNT, LOAD, VERIFY, SYNC; the reset state is HUNT.
REQ-018 HUNT: on the next sampled bit, clear the load counter and go to LOAD.
REQ-019 LOAD: shift received bits into r until 7 bits are loaded.
REQ-020 LOAD exit: if r is all-zero after 7 bits, restart LOAD (lock-up guard); otherwise go to VERIFY.
REQ-021 VERIFY: compare each received bit with the prediction, then shift the received bit into r.
REQ-022 VERIFY exit: SYNC_BITS consecutive matches go to SYNC; any mismatch goes to HUNT.
REQ-023 SYNC free-run: r shifts in the predicted bit, not the received bit, so a single channel error counts exactly once.
REQ-024 SYNC error handling: a mismatch pulses err_pulse and increments err_cnt, saturating at 65535.
REQ-025 SYNC window: a 7-bit window counter wraps 126->0; the window error count clears on wrap.
REQ-026 Loss of sync: when the window error count reaches LOSS_ERRS, go to HUNT on that bit; err_cnt holds its value.
REQ-027 Simultaneous events: a window wrap and an error on the same bit count the error in the new window.
REQ-028 err_cnt clears only on reset or on a VERIFY->SYNC transition.
REQ-029 in_sync is registered and reflects the state after the current clk_2m edge.
REQ-030 bit_clk_in stopped: state and counters hold; no timeout is applied.

Reset
REQ-031 With rst high at a clk_2m edge: state=HUNT; r, all counters and both synchronisers cleared.
REQ-032 During reset: in_sync=0, bit_valid=0, err_pulse=0, err_cnt=0, period_cnt=0.
REQ-033 Reset mid-operation takes effect at the next clk_2m edge and abandons any in-flight bit.

Configuration
REQ-034 Macro CHK_PERIOD_CNT_EN defined: in SYNC, period_cnt increments (wrapping at 65535->0) each time r equals 7'b1111111.
REQ-035 Macro CHK_PERIOD_CNT_EN undefined: period_cnt is tied to 0 and no counter logic is synthesised.

Verification
REQ-036 Clean sequence, any phase, 10 kHz bit clock -> in_sync rises after bit 23 (7 load + 16 verify); err_cnt stays 0 over 1000 bits.
REQ-037 One flipped bit while in SYNC -> exactly one err_pulse; err_cnt=1; in_sync stays 1.
REQ-038 8 flipped bits within one 127-bit window -> in_sync falls on the 8th error; state HUNT; sync regained after 23 further clean bits.
REQ-039 Constant-zero input -> in_sync never asserts; state cycles in LOAD.
REQ-040 rst pulsed while in SYNC with err_cnt=5 -> next cycle: in_sync=0, err_cnt=0.
REQ-041 CHK_PERIOD_CNT_EN defined, 3 full periods in SYNC -> period_cnt=3; macro undefined -> period_cnt=0.
